// File: rtl/gf_mac_pkg.sv
// Shared types and field arithmetic for the GF(2^W) MAC engine.
// Optional feature macro used by the top: GF_MAC_TAG_MASK_EN.
package gf_mac_pkg;

  // Widest field supported; helpers operate on this width and mask to w.
  localparam int GF_WMAX = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RDY  = 2'd1,
    S_MUL  = 2'd2,
    S_OUT  = 2'd3
  } gf_state_e;

  // Multiply z by x in GF(2^w): shift left one bit, fold the bit that
  // leaves position w-1 back in through the reduction polynomial.
  function automatic logic [GF_WMAX-1:0] gf_xtime(
    input logic [GF_WMAX-1:0] z,
    input logic [GF_WMAX-1:0] poly,
    input int                 w
  );
    logic [GF_WMAX-1:0] r;
    logic               msb;
    r   = '0;
    msb = 1'b0;
    for (int b = 0; b < GF_WMAX; b++) begin
      if (b == w - 1) begin
        msb = z[b];
      end
    end
    for (int b = 1; b < GF_WMAX; b++) begin
      if (b < w) begin
        r[b] = z[b-1];
      end
    end
    for (int b = 0; b < GF_WMAX; b++) begin
      if (b < w) begin
        r[b] = r[b] ^ (poly[b] & msb);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_mac_engine_mul_digit.sv
// One digit-serial Horner step for a single GF(2^W) lane:
// for each of the DIGIT bits, MSB first, z = xtime(z) ^ (bit ? H : 0).
module gf_mul_digit
  import gf_mac_pkg::*;
#(
  parameter int             W     = 8,
  parameter int             DIGIT = 1,
  parameter logic [W-1:0]   POLY  = 8'h1B
) (
  input  logic [W-1:0]     z_i,
  input  logic [W-1:0]     h_i,
  input  logic [DIGIT-1:0] digit_i,
  output logic [W-1:0]     z_o
);

  logic [GF_WMAX-1:0] za_s;
  logic [GF_WMAX-1:0] hx_s;
  logic [GF_WMAX-1:0] px_s;

  // Widen operands to the helper width, then run DIGIT Horner steps.
  always_comb begin
    za_s = '0;
    hx_s = '0;
    px_s = '0;
    za_s[W-1:0] = z_i;
    hx_s[W-1:0] = h_i;
    px_s[W-1:0] = POLY;
    for (int j = DIGIT - 1; j >= 0; j--) begin
      if (digit_i[j]) begin
        za_s = gf_xtime(za_s, px_s, W) ^ hx_s;
      end else begin
        za_s = gf_xtime(za_s, px_s, W);
      end
    end
    z_o = za_s[W-1:0];
  end

endmodule

// File: rtl/gf_mac_engine.sv
// Multi-lane GF(2^W) multiply-accumulate engine: acc = (acc ^ data) * H per
// lane, digit-serial multiply, valid/ready block input and tag output.
// Optional feature: define GF_MAC_TAG_MASK_EN to add a tag_mask input that is
// captured on the final block and XORed into tag_data.
module gf_mac_engine
  import gf_mac_pkg::*;
#(
  parameter int           W     = 8,
  parameter int           LANES = 16,
  parameter int           DIGIT = 1,
  parameter logic [W-1:0] POLY  = 8'h1B
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_load,
  input  logic [LANES*W-1:0]   key_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_data,
`ifdef GF_MAC_TAG_MASK_EN
  input  logic [LANES*W-1:0]   tag_mask,
`endif
  input  logic                 in_last,
  output logic                 tag_valid,
  input  logic                 tag_ready,
  output logic [LANES*W-1:0]   tag_data,
  output logic                 busy
);

  localparam int NB    = LANES * W;
  localparam int STEPS = W / DIGIT;
  localparam int CW    = $clog2(STEPS + 1);

  gf_state_e       state_q;
  logic [NB-1:0]   h_q;
  logic [NB-1:0]   acc_q;
  logic [NB-1:0]   opnd_q;
  logic [NB-1:0]   z_q;
  logic [NB-1:0]   z_d;
  logic [CW-1:0]   cnt_q;
  logic            last_q;
  logic [NB-1:0]   mask_q;

  // Per-lane multiplier slice; the digit is picked by cnt, MSB digit first.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DIGIT-1:0] dig_s;
    assign dig_s = opnd_q[i*W + (W-1) - int'(cnt_q)*DIGIT -: DIGIT];
    gf_mul_digit #(
      .W     (W),
      .DIGIT (DIGIT),
      .POLY  (POLY)
    ) u_mul (
      .z_i     (z_q[i*W +: W]),
      .h_i     (h_q[i*W +: W]),
      .digit_i (dig_s),
      .z_o     (z_d[i*W +: W])
    );
  end

  assign in_ready  = (state_q == S_RDY) && !key_load;
  assign tag_valid = (state_q == S_OUT);
  assign busy      = (state_q == S_MUL) || (state_q == S_OUT);
  assign tag_data  = acc_q ^ mask_q;

  // Control FSM plus key, accumulator, operand and partial-product registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      mask_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_load) begin
            h_q     <= key_data;
            acc_q   <= '0;
            state_q <= S_RDY;
          end
        end
        S_RDY: begin
          if (key_load) begin
            h_q   <= key_data;
            acc_q <= '0;
          end else if (in_valid) begin
            opnd_q  <= acc_q ^ in_data;
            cnt_q   <= '0;
            last_q  <= in_last;
            z_q     <= '0;
            state_q <= S_MUL;
`ifdef GF_MAC_TAG_MASK_EN
            if (in_last) begin
              mask_q <= tag_mask;
            end
`endif
          end
        end
        S_MUL: begin
          z_q   <= z_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(STEPS - 1)) begin
            acc_q   <= z_d;
            state_q <= last_q ? S_OUT : S_RDY;
          end
        end
        S_OUT: begin
          if (tag_ready) begin
            acc_q   <= '0;
            state_q <= S_RDY;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mac_engine.sv
// Self-checking bench: three engines (DIGIT = 1, 2, 4; W = 8, LANES = 2),
// directed field vectors plus random messages against a carry-less
// multiply-and-reduce reference model.
module tb_gf_mac_engine;

  localparam int LANES = 2;
  localparam int NB    = LANES * 8;
  localparam int NDUT  = 3;

  logic          clk;
  logic          rst;
  logic          key_load  [NDUT];
  logic [NB-1:0] key_data  [NDUT];
  logic          in_valid  [NDUT];
  logic          in_ready  [NDUT];
  logic [NB-1:0] in_data   [NDUT];
  logic          in_last   [NDUT];
  logic          tag_valid [NDUT];
  logic          tag_ready [NDUT];
  logic [NB-1:0] tag_data  [NDUT];
  logic          busy      [NDUT];
`ifdef GF_MAC_TAG_MASK_EN
  logic [NB-1:0] tag_mask  [NDUT];
  logic [NB-1:0] mask_m    [NDUT];
`endif

  logic [7:0] h_m   [NDUT][LANES];
  logic [7:0] acc_m [NDUT][LANES];

  int n_chk;
  int n_pass;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    gf_mac_engine #(
      .W     (8),
      .LANES (LANES),
      .DIGIT (32'd1 << g),
      .POLY  (8'h1B)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .key_load  (key_load[g]),
      .key_data  (key_data[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
`ifdef GF_MAC_TAG_MASK_EN
      .tag_mask  (tag_mask[g]),
`endif
      .in_last   (in_last[g]),
      .tag_valid (tag_valid[g]),
      .tag_ready (tag_ready[g]),
      .tag_data  (tag_data[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: full carry-less product, then long-division reduction by x^8+POLY.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (a[i]) p = p ^ (16'(b) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [NB-1:0] exp_tag(input int d);
    logic [NB-1:0] t;
    for (int l = 0; l < LANES; l++) t[l*8 +: 8] = acc_m[d][l];
`ifdef GF_MAC_TAG_MASK_EN
    t = t ^ mask_m[d];
`endif
    return t;
  endfunction

  task automatic load_key(input int d, input logic [NB-1:0] k);
    @(negedge clk);
    key_load[d] = 1'b1;
    key_data[d] = k;
    @(posedge clk);
    #1;
    key_load[d] = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      h_m[d][l]   = k[l*8 +: 8];
      acc_m[d][l] = 8'h00;
    end
  endtask

  task automatic send_block(input int d, input logic [NB-1:0] data, input logic last,
                            input logic [NB-1:0] mask);
    int n;
    int lat;
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    in_last[d]  = last;
`ifdef GF_MAC_TAG_MASK_EN
    tag_mask[d] = mask;
`endif
    n = 0;
    while (!in_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    chk("busy_after_accept", 32'(busy[d]), 32'd1);
    chk("in_ready_in_mul", 32'(in_ready[d]), 32'd0);
    for (int l = 0; l < LANES; l++)
      acc_m[d][l] = gf_ref(acc_m[d][l] ^ data[l*8 +: 8], h_m[d][l]);
`ifdef GF_MAC_TAG_MASK_EN
    if (last) mask_m[d] = mask;
`endif
    lat = 0;
    while (!(tag_valid[d] || in_ready[d]) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(8 >> d));
    chk("tag_valid_after_mul", 32'(tag_valid[d]), 32'(last));
    chk("in_ready_after_mul", 32'(in_ready[d]), 32'(!last));
  endtask

  task automatic get_tag(input int d, input int hold, input logic [NB-1:0] exp);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("tag_hold_data", 32'(tag_data[d]), 32'(exp));
      chk("tag_hold_valid", 32'(tag_valid[d]), 32'd1);
      chk("tag_hold_in_ready", 32'(in_ready[d]), 32'd0);
    end
    @(negedge clk);
    chk("tag_data", 32'(tag_data[d]), 32'(exp));
    tag_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    tag_ready[d] = 1'b0;
    chk("tag_valid_drop", 32'(tag_valid[d]), 32'd0);
    chk("in_ready_after_tag", 32'(in_ready[d]), 32'd1);
    chk("busy_after_tag", 32'(busy[d]), 32'd0);
    for (int l = 0; l < LANES; l++) acc_m[d][l] = 8'h00;
  endtask

  logic [NB-1:0] mtag;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      key_load[d]  = 1'b0;
      key_data[d]  = '0;
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      in_last[d]   = 1'b0;
      tag_ready[d] = 1'b0;
`ifdef GF_MAC_TAG_MASK_EN
      tag_mask[d]  = '0;
      mask_m[d]    = '0;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    for (int d = 0; d < NDUT; d++) begin
      @(negedge clk);
      in_valid[d] = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready[d]), 32'd0);
      chk("rst_tag_valid", 32'(tag_valid[d]), 32'd0);
      chk("rst_tag_data", 32'(tag_data[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      in_valid[d] = 1'b0;
    end

    // Two lanes with different keys on the bit-serial engine.
    load_key(0, 16'h0283);
    send_block(0, 16'h5757, 1'b1, 16'h0000);
    get_tag(0, 0, 16'hAEC1);

    // Same product on every digit width.
    for (int d = 0; d < NDUT; d++) begin
      load_key(d, 16'h1313);
      send_block(d, 16'h5757, 1'b1, 16'h0000);
      get_tag(d, 0, 16'hFEFE);
    end

    // Two-block message with a stalled tag consumer.
    load_key(0, 16'h0101);
    send_block(0, 16'h1212, 1'b0, 16'h0000);
    send_block(0, 16'h3434, 1'b1, 16'h0000);
    get_tag(0, 5, 16'h2626);

    // Tag mask path (or plain tag when the option is absent).
    load_key(0, 16'h8383);
    send_block(0, 16'h5757, 1'b1, 16'hFFFF);
`ifdef GF_MAC_TAG_MASK_EN
    get_tag(0, 0, 16'h3E3E);
`else
    get_tag(0, 0, 16'hC1C1);
`endif

    // key_load beats a simultaneous block and clears the accumulator.
    load_key(0, 16'h0101);
    send_block(0, 16'h1212, 1'b0, 16'h0000);
    @(negedge clk);
    key_load[0] = 1'b1;
    key_data[0] = 16'h8383;
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h9999;
    in_last[0]  = 1'b1;
    #1;
    chk("kl_blocks_in_ready", 32'(in_ready[0]), 32'd0);
    @(posedge clk);
    #1;
    key_load[0] = 1'b0;
    in_valid[0] = 1'b0;
    chk("kl_no_accept_busy", 32'(busy[0]), 32'd0);
    chk("kl_acc_cleared", 32'(tag_data[0]), 32'd0);
    for (int l = 0; l < LANES; l++) begin
      h_m[0][l]   = 8'h83;
      acc_m[0][l] = 8'h00;
    end
    send_block(0, 16'h5757, 1'b1, 16'h0000);
    get_tag(0, 0, 16'hC1C1);

    // Random messages against the reference model on every engine.
    for (int d = 0; d < NDUT; d++) begin
      for (int m = 0; m < 6; m++) begin
        int nb;
        if (m == 0 || $urandom_range(1, 0) == 1) load_key(d, NB'($urandom));
        nb = $urandom_range(3, 1);
        for (int b = 0; b < nb; b++)
          send_block(d, NB'($urandom), (b == nb - 1), NB'($urandom));
        mtag = exp_tag(d);
        get_tag(d, $urandom_range(3, 0), mtag);
      end
    end

    // Reset in the middle of a multiply: engine must stay keyless.
    load_key(0, 16'h1313);
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h5757;
    in_last[0]  = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy_before", 32'(busy[0]), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd0);
      chk("mid_rst_busy", 32'(busy[0]), 32'd0);
      chk("mid_rst_tag_valid", 32'(tag_valid[0]), 32'd0);
    end
    chk("mid_rst_tag_data", 32'(tag_data[0]), 32'd0);
    in_valid[0] = 1'b0;
    load_key(0, 16'h0283);
    send_block(0, 16'h5757, 1'b1, 16'h0000);
    get_tag(0, 0, 16'hAEC1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
